// File: rtl/seq_loader.sv
// UART byte stream to 3-bit nucleotide codes for sequence memories A and B.
// Optional feature macro: LOWERCASE_EN (accept g/c/a/t as well as G/C/A/T).
module seq_loader #(
    parameter int N       = 8,
    parameter int MAX_LEN = 16,
    parameter int AW      = $clog2(MAX_LEN),
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  Rxdata_out,
    input  logic          rx_valid,
    input  logic          start,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [AW-1:0] wr_addr,
    output logic [2:0]    char,
    output logic [LW-1:0] len_a,
    output logic [LW-1:0] len_b,
    output logic          busy,
    output logic          done,
    output logic          err_invalid,
    output logic          err_overflow
);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

    state_t        state;
    logic [7:0]    lo;
    logic          hi_zero;
    logic [2:0]    code;
    logic          is_term;
    logic [LW-1:0] cur_len;
    logic          loading;

    assign lo      = Rxdata_out[7:0];
    assign hi_zero = ((Rxdata_out >> 8) == '0);
    assign loading = (state == LOAD_A) || (state == LOAD_B);
    assign cur_len = (state == LOAD_B) ? len_b : len_a;

    always_comb begin
        code    = '0;
        is_term = 1'b0;
        if (hi_zero) begin
            case (lo)
                8'h47: code = 3'b001;
                8'h43: code = 3'b110;
                8'h41: code = 3'b100;
                8'h54: code = 3'b011;
`ifdef LOWERCASE_EN
                8'h67: code = 3'b001;
                8'h63: code = 3'b110;
                8'h61: code = 3'b100;
                8'h74: code = 3'b011;
`endif
                8'h0A, 8'h0D: is_term = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_en        <= 1'b0;
            wr_sel       <= 1'b0;
            wr_addr      <= '0;
            char         <= '0;
            len_a        <= '0;
            len_b        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_invalid  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            char  <= '0;
            if (start) begin
                // start wins over a coincident byte, which is dropped
                state        <= LOAD_A;
                busy         <= 1'b1;
                done         <= 1'b0;
                len_a        <= '0;
                len_b        <= '0;
                err_invalid  <= 1'b0;
                err_overflow <= 1'b0;
            end else if (rx_valid && loading) begin
                if (code != 3'b000) begin
                    if (cur_len < LW'(MAX_LEN)) begin
                        wr_en   <= 1'b1;
                        wr_sel  <= (state == LOAD_B);
                        wr_addr <= cur_len[AW-1:0];
                        char    <= code;
                        if (state == LOAD_B) len_b <= len_b + LW'(1);
                        else                 len_a <= len_a + LW'(1);
                    end else begin
                        err_overflow <= 1'b1;
                    end
                end else if (is_term) begin
                    // empty-line terminators (e.g. LF of CRLF) are ignored
                    if (cur_len != '0) begin
                        if (state == LOAD_A) begin
                            state <= LOAD_B;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end else begin
                    err_invalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_loader.sv
// Directed bench for seq_loader: per-cycle comparison against a sequence-level
// model plus hand-computed checks of memory contents, lengths and flags.
module tb_seq_loader;
    localparam int N       = 8;
    localparam int MAX_LEN = 4;
    localparam int AW      = $clog2(MAX_LEN);
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          start = 1'b0;
    logic          wr_en, wr_sel, busy, done, err_invalid, err_overflow;
    logic [AW-1:0] wr_addr;
    logic [2:0]    char;
    logic [LW-1:0] len_a, len_b;

    seq_loader #(.N(N), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .Rxdata_out(rx_data), .rx_valid(rx_valid),
        .start(start), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .char(char), .len_a(len_a), .len_b(len_b), .busy(busy), .done(done),
        .err_invalid(err_invalid), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---- model: one phase number and two lengths describe the loader ----
    int ph = 0;              // 0 idle, 1 loading A, 2 loading B, 3 done
    int ml[2] = '{0, 0};
    int ew = 0, esel = 0, eaddr = 0, echar = 0, einv = 0, eovf = 0;

    function automatic int nuc(input logic [7:0] b);
        string up = "GCAT";
        string lw = "gcat";
        int codes[4] = '{1, 6, 4, 3};
        for (int i = 0; i < 4; i++) begin
            if (b == up[i]) return codes[i];
`ifdef LOWERCASE_EN
            if (b == lw[i]) return codes[i];
`endif
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; ml = '{0, 0};
            ew = 0; esel = 0; eaddr = 0; echar = 0; einv = 0; eovf = 0;
        end else begin
            ew = 0; echar = 0;
            if (start) begin
                ph = 1; ml = '{0, 0}; einv = 0; eovf = 0;
            end else if (rx_valid && (ph == 1 || ph == 2)) begin
                int s;
                int c;
                s = ph - 1;
                c = nuc(rx_data);
                if (c != 0) begin
                    if (ml[s] < MAX_LEN) begin
                        ew = 1; esel = s; eaddr = ml[s]; echar = c; ml[s]++;
                    end else eovf = 1;
                end else if (rx_data == 8'h0A || rx_data == 8'h0D) begin
                    if (ml[s] > 0) ph++;
                end else einv = 1;
            end
        end
    end

    // ---- capture of DUT writes into shadow memories, and compare process ----
    int mem_a[MAX_LEN];
    int mem_b[MAX_LEN];
    int nwr = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            nwr++;
            if (wr_sel) mem_b[wr_addr] = char;
            else        mem_a[wr_addr] = char;
        end
        if (chk_on) begin
            chk("wr_en", wr_en, ew);
            chk("wr_sel", wr_sel, esel);
            chk("wr_addr", wr_addr, eaddr);
            chk("char", char, echar);
            chk("len_a", len_a, ml[0]);
            chk("len_b", len_b, ml[1]);
            chk("busy", busy, (ph == 1 || ph == 2) ? 1 : 0);
            chk("done", done, (ph == 3) ? 1 : 0);
            chk("err_invalid", err_invalid, einv);
            chk("err_overflow", err_overflow, eovf);
        end
    end

    // ---- stimulus ----
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = s[i];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = '0;
        #1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    initial begin
        int w0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        #1;
        chk("rst wr_en", wr_en, 0);
        chk("rst char", char, 0);
        chk("rst lens", len_a + len_b, 0);
        chk("rst busy/done", {busy, done}, 0);
        @(negedge clk);
        rst = 1'b0;

        // "GCAT\n" into A, then "TA\r\n" into B
        do_start();
        chk("start busy", busy, 1);
        send_str("GCAT\n");
        chk("A[0]", mem_a[0], 1);
        chk("A[1]", mem_a[1], 6);
        chk("A[2]", mem_a[2], 4);
        chk("A[3]", mem_a[3], 3);
        chk("len_a GCAT", len_a, 4);
        chk("LOAD_B busy", {busy, done}, 2);
        send_str("TA\r\n");
        chk("B[0]", mem_b[0], 3);
        chk("B[1]", mem_b[1], 4);
        chk("len_b TA", len_b, 2);
        chk("done TA", {busy, done}, 1);
        send_str("GG\n");
        chk("DONE ignores bytes", {len_a, len_b, err_invalid}, {3'd4, 3'd2, 1'b0});

        // overflow: fifth nucleotide dropped, terminator still advances
        do_start();
        w0 = nwr;
        send_str("AAAAAG\n");
        chk("ovf writes", nwr - w0, 4);
        chk("ovf flag", err_overflow, 1);
        chk("ovf len_a", len_a, 4);
        chk("ovf to LOAD_B", {busy, done}, 2);

        // invalid byte and lowercase handling
        do_start();
        send_str("AXg\n");
        chk("inv flag", err_invalid, 1);
`ifdef LOWERCASE_EN
        chk("lower len_a", len_a, 2);
        chk("lower A[1]", mem_a[1], 1);
`else
        chk("lower len_a", len_a, 1);
`endif

        // start with a coincident byte mid-LOAD_B
        send_str("C");
        w0 = nwr;
        @(negedge clk);
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h43;
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b0;
        #1;
        chk("restart no write", nwr - w0, 0);
        chk("restart clears", {len_a, len_b, err_invalid, err_overflow}, 0);
        chk("restart LOAD_A", {busy, done}, 2);

        // blank line ignored in LOAD_A
        send_str("\nG\n");
        chk("blank len_a", len_a, 1);
        chk("blank to LOAD_B", {busy, done}, 2);

        // reset during loading with a byte present
        do_start();
        send_str("GX");
        w0 = nwr;
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h41;
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0;
        #1;
        chk("rst no write", nwr - w0, 0);
        chk("rst mid outputs", {wr_en, wr_sel, wr_addr, char, busy, done, err_invalid, err_overflow}, 0);
        chk("rst mid lens", {len_a, len_b}, 0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
